// File: rtl/mux_arb_pipe_if.sv
// mux_arb_pipe_if: channel inputs, select controls and registered output of the arbiter mux
interface mux_arb_pipe_if #(
  parameter int WIDTH = 64,
  parameter int NCH   = 3,
  parameter int SELW  = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_idx;
  logic                 sel_err;
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_idx, sel_err
  );
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_idx, sel_err
  );
endinterface

// File: rtl/mux_arb_pipe.sv
// mux_arb_pipe: NCH-way mux with explicit select or round-robin arbitration into one output register
module mux_arb_pipe #(
  parameter int WIDTH = 64,
  parameter int NCH   = 3,
  parameter int SELW  = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
  input logic          clk,
  input logic          rst_n,
  mux_arb_pipe_if.slave bus
);
  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_idx, r_rr;
  logic             r_valid, r_err;
  logic             w_load, w_sel_bad, w_rr_vld, w_cand_vld, w_xfer;
  logic [SELW-1:0]  w_rr_idx, w_cand;
  assign w_load    = !r_valid || bus.out_ready;
  assign w_sel_bad = {1'b0, bus.sel} >= NCH_W;
  // scan downward so the first valid channel after r_rr wins
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    for (int k = NCH; k >= 1; k--)
      if (bus.in_valid[(int'(r_rr) + k) % NCH]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = SELW'((int'(r_rr) + k) % NCH);
      end
  end
  assign w_cand_vld = bus.mode ? w_rr_vld : !w_sel_bad;
  assign w_cand     = !w_cand_vld ? '0 : bus.mode ? w_rr_idx : bus.sel;
  for (genvar i = 0; i < NCH; i++) begin : g_rdy
    assign bus.in_ready[i] = rst_n && w_load && w_cand_vld && (w_cand == SELW'(i));
  end
  assign w_xfer = |(bus.in_valid & bus.in_ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rr    <= SELW'(NCH-1);
    end else begin
      if (w_load) r_valid <= w_xfer;
      if (w_load && w_xfer) begin
        r_data <= bus.in_data[w_cand*WIDTH +: WIDTH];
        r_idx  <= w_cand;
      end
      if (w_xfer && bus.mode) r_rr <= w_cand;
      r_err <= !bus.mode && w_sel_bad;
    end
  end
  assign bus.out_data  = r_data;
  assign bus.out_idx   = r_idx;
  assign bus.out_valid = r_valid;
  assign bus.sel_err   = r_err;
endmodule

// File: tb/tb_mux_arb_pipe.sv
// tb_mux_arb_pipe: directed scenario tasks for mux_arb_pipe (NCH=3, WIDTH=64)
module tb_mux_arb_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  mux_arb_pipe_if #(.WIDTH(64), .NCH(3)) bus ();
  mux_arb_pipe #(.WIDTH(64), .NCH(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.in_data = {64'd30, 64'd20, 64'd10};
    bus.in_valid = 3'b111; bus.mode = 1'b0; bus.sel = 2'd0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 64'd0) $display("FAIL rst_data got %0d want 0", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_idx !== 2'd0) $display("FAIL rst_idx got %0d want 0", bus.out_idx); else pass_cnt++;
    total_cnt++; if (bus.sel_err !== 1'b0) $display("FAIL rst_err got %0b want 0", bus.sel_err); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 3'b000) $display("FAIL rst_ready got %b want 000", bus.in_ready); else pass_cnt++;
    rst_n = 1'b1;
    bus.in_valid = 3'b000;
    tick();
  endtask
  task automatic test_mode0_select();
    bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 3'b111; bus.out_ready = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 3'b010) $display("FAIL m0_ready got %b want 010", bus.in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (bus.out_data !== 64'd20) $display("FAIL m0_data got %0d want 20", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_idx !== 2'd1) $display("FAIL m0_idx got %0d want 1", bus.out_idx); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL m0_valid got %0b want 1", bus.out_valid); else pass_cnt++;
    bus.in_valid = 3'b000;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL m0_drain_valid got %0b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 64'd20) $display("FAIL m0_hold_data got %0d want 20", bus.out_data); else pass_cnt++;
  endtask
  task automatic test_sel_err();
    bus.mode = 1'b0; bus.sel = 2'd3; bus.in_valid = 3'b111; bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total_cnt++; if (bus.in_ready !== 3'b000) $display("FAIL err_ready[%0d] got %b want 000", c, bus.in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (bus.sel_err !== 1'b1) $display("FAIL err_pulse[%0d] got %0b want 1", c, bus.sel_err); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL err_valid[%0d] got %0b want 0", c, bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.out_data !== 64'd20) $display("FAIL err_data[%0d] got %0d want 20", c, bus.out_data); else pass_cnt++;
    end
    bus.sel = 2'd0; bus.in_valid = 3'b000;
    tick();
    total_cnt++; if (bus.sel_err !== 1'b0) $display("FAIL err_clear got %0b want 0", bus.sel_err); else pass_cnt++;
  endtask
  task automatic test_rr_all();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.mode = 1'b1; bus.sel = 2'd3; bus.in_valid = 3'b111; bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total_cnt++;
      if (bus.out_idx !== 2'(c % 3) || bus.out_valid !== 1'b1 || bus.out_data !== 64'((c % 3 + 1) * 10))
        $display("FAIL rr_all[%0d] got idx=%0d v=%0b d=%0d want idx=%0d v=1 d=%0d", c, bus.out_idx, bus.out_valid, bus.out_data, c % 3, (c % 3 + 1) * 10);
      else pass_cnt++;
    end
  endtask
  task automatic test_rr_skip();
    logic [2:0] exp_rdy [3] = '{3'b100, 3'b001, 3'b100};
    logic [1:0] exp_idx [3] = '{2'd2, 2'd0, 2'd2};
    bus.mode = 1'b1; bus.in_valid = 3'b001; bus.out_ready = 1'b1;
    tick();
    total_cnt++; if (bus.out_idx !== 2'd0) $display("FAIL skip_setup got %0d want 0", bus.out_idx); else pass_cnt++;
    bus.in_valid = 3'b101;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++; if (bus.in_ready !== exp_rdy[c]) $display("FAIL skip_ready[%0d] got %b want %b", c, bus.in_ready, exp_rdy[c]); else pass_cnt++;
      tick();
      total_cnt++; if (bus.out_idx !== exp_idx[c]) $display("FAIL skip_idx[%0d] got %0d want %0d", c, bus.out_idx, exp_idx[c]); else pass_cnt++;
    end
  endtask
  task automatic test_backpressure();
    logic [2:0] pat [4] = '{3'b010, 3'b111, 3'b100, 3'b011};
    bus.mode = 1'b1; bus.in_valid = 3'b111; bus.out_ready = 1'b1;
    tick();
    total_cnt++; if (bus.out_idx !== 2'd0 || bus.out_data !== 64'd10) $display("FAIL bp_first got idx=%0d d=%0d want idx=0 d=10", bus.out_idx, bus.out_data); else pass_cnt++;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = pat[c]; bus.mode = c[0]; bus.sel = 2'(c);
      #1;
      total_cnt++; if (bus.in_ready !== 3'b000) $display("FAIL bp_ready[%0d] got %b want 000", c, bus.in_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd0 || bus.out_data !== 64'd10)
        $display("FAIL bp_hold[%0d] got v=%0b idx=%0d d=%0d want v=1 idx=0 d=10", c, bus.out_valid, bus.out_idx, bus.out_data);
      else pass_cnt++;
    end
    bus.mode = 1'b1; bus.in_valid = 3'b111; bus.out_ready = 1'b1;
    tick();
    total_cnt++; if (bus.out_idx !== 2'd1 || bus.out_data !== 64'd20) $display("FAIL bp_release got idx=%0d d=%0d want idx=1 d=20", bus.out_idx, bus.out_data); else pass_cnt++;
  endtask
  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0) $display("FAIL ar_clear got v=%0b d=%0d want v=0 d=0", bus.out_valid, bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 3'b000) $display("FAIL ar_ready got %b want 000", bus.in_ready); else pass_cnt++;
    #2;
    rst_n = 1'b1;
    bus.mode = 1'b1; bus.in_valid = 3'b111; bus.out_ready = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 3'b001) $display("FAIL ar_grant got %b want 001", bus.in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (bus.out_idx !== 2'd0 || bus.out_data !== 64'd10 || bus.out_valid !== 1'b1) $display("FAIL ar_first got idx=%0d d=%0d want idx=0 d=10", bus.out_idx, bus.out_data); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_mode0_select();
    test_sel_err();
    test_rr_all();
    test_rr_skip();
    test_backpressure();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
